// File: rtl/vga_tile_renderer_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_tile_renderer_if
// Brief    : Game-logic side of the tile renderer: tile writes and map commits.
// Revision : 1.0
// ============================================================================
interface vga_tile_renderer_if;
    logic       wr_req;
    logic [1:0] wr_x;
    logic [2:0] wr_y;
    logic [2:0] wr_code;
    logic       wr_ack;
    logic       commit;
    logic       commit_done;

    modport master (
        output wr_req, wr_x, wr_y, wr_code, commit,
        input  wr_ack, commit_done
    );

    modport slave (
        input  wr_req, wr_x, wr_y, wr_code, commit,
        output wr_ack, commit_done
    );
endinterface
`default_nettype wire

// File: rtl/vga_tile_renderer.sv
`default_nettype none
// ============================================================================
// Module   : vga_tile_renderer
// Brief    : 4x5 tile board renderer with double-buffered tile map and cursor.
// Revision : 1.0
// ============================================================================
module vga_tile_renderer (
    input  wire logic        clk,
    input  wire logic        rstn,
    input  wire logic        rdn,
    input  wire logic [8:0]  row,
    input  wire logic [9:0]  col,
    output logic      [11:0] dout,
    input  wire logic        cursor_en,
    input  wire logic [1:0]  cursor_x,
    input  wire logic [2:0]  cursor_y,
    vga_tile_renderer_if.slave wr_bus
);
    localparam logic [9:0] BOARD_LEFT  = 10'd128;
    localparam logic [9:0] BOARD_RIGHT = 10'd511;
    localparam logic [8:0] ROW_LAST    = 9'd479;
    localparam logic [8:0] FRAME_ROW   = 9'd480;

    logic [19:0][2:0] shadow_q, shadow_d;
    logic [19:0][2:0] active_q, active_d;
    logic             pending_q, pending_d;
    logic [4:0]       blink_q, blink_d;
    logic             frame_hist_q, frame_hist_d;
    logic             wr_ack_q, wr_ack_d;
    logic             commit_done_q, commit_done_d;

    logic frame_cond, frame_start, swap, wr_accept;

    // A write accepted on the swap edge sees the old shadow copied, so it lands
    // only in shadow; a commit on that edge re-arms pending for the next frame.
    always_comb begin
        frame_cond    = rdn && (row == FRAME_ROW);
        frame_start   = frame_cond && !frame_hist_q;
        swap          = frame_start && pending_q;
        wr_accept     = wr_bus.wr_req && !wr_ack_q;
        shadow_d      = shadow_q;
        if (wr_accept && (wr_bus.wr_y <= 3'd4))
            shadow_d[{wr_bus.wr_y, wr_bus.wr_x}] = wr_bus.wr_code;
        active_d      = swap ? shadow_q : active_q;
        pending_d     = swap ? wr_bus.commit : (pending_q | wr_bus.commit);
        blink_d       = blink_q + {4'd0, frame_start};
        frame_hist_d  = frame_cond;
        wr_ack_d      = wr_accept;
        commit_done_d = swap;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_q      <= '0;
            active_q      <= '0;
            pending_q     <= 1'b0;
            blink_q       <= 5'd0;
            frame_hist_q  <= 1'b0;
            wr_ack_q      <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            blink_q       <= blink_d;
            frame_hist_q  <= frame_hist_d;
            wr_ack_q      <= wr_ack_d;
            commit_done_q <= commit_done_d;
        end
    end

    assign wr_bus.wr_ack      = wr_ack_q;
    assign wr_bus.commit_done = commit_done_q;

    logic [9:0] col_off, x_base, lx;
    logic [8:0] y_base, ly;
    logic [1:0] tx;
    logic [2:0] ty;
    logic [4:0] tile_idx;
    logic       on_border, cursor_hit;

    // Tile coordinates via threshold compares instead of dividing by 96.
    always_comb begin
        col_off = col - BOARD_LEFT;
        tx      = 2'd0;
        x_base  = 10'd0;
        if (col_off >= 10'd288)      begin tx = 2'd3; x_base = 10'd288; end
        else if (col_off >= 10'd192) begin tx = 2'd2; x_base = 10'd192; end
        else if (col_off >= 10'd96)  begin tx = 2'd1; x_base = 10'd96;  end
        ty      = 3'd0;
        y_base  = 9'd0;
        if (row >= 9'd384)      begin ty = 3'd4; y_base = 9'd384; end
        else if (row >= 9'd288) begin ty = 3'd3; y_base = 9'd288; end
        else if (row >= 9'd192) begin ty = 3'd2; y_base = 9'd192; end
        else if (row >= 9'd96)  begin ty = 3'd1; y_base = 9'd96;  end
        lx         = col_off - x_base;
        ly         = row - y_base;
        tile_idx   = {ty, tx};
        on_border  = (lx < 10'd2) || (lx > 10'd93) || (ly < 9'd2) || (ly > 9'd93);
        cursor_hit = cursor_en && (tx == cursor_x) && (ty == cursor_y) && !blink_q[4];

        dout = 12'h000;
        if (!rdn && (col >= BOARD_LEFT) && (col <= BOARD_RIGHT) && (row <= ROW_LAST)) begin
            if (on_border) begin
                dout = cursor_hit ? 12'h0FF : 12'h000;
            end else begin
                case (active_q[tile_idx])
                    3'd0:    dout = 12'h444;
                    3'd1:    dout = 12'h00F;
                    3'd2:    dout = 12'h0F0;
                    3'd3:    dout = 12'hF00;
                    3'd4:    dout = 12'hFF0;
                    3'd5:    dout = 12'hF0F;
                    3'd6:    dout = 12'h08F;
                    default: dout = 12'hFFF;
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vga_tile_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_tile_renderer
// Brief    : Self-checking bench with a tile-level reference model.
// Revision : 1.0
// ============================================================================
module tb_vga_tile_renderer;
    localparam int HALF = 50;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rdn = 1'b0;
    logic [8:0]  row = 9'd0;
    logic [9:0]  col = 10'd0;
    logic [11:0] dout;
    logic        cursor_en = 1'b0;
    logic [1:0]  cursor_x = 2'd0;
    logic [2:0]  cursor_y = 3'd0;

    vga_tile_renderer_if bus ();

    vga_tile_renderer dut (
        .clk       (clk),
        .rstn      (rstn),
        .rdn       (rdn),
        .row       (row),
        .col       (col),
        .dout      (dout),
        .cursor_en (cursor_en),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .wr_bus    (bus.slave)
    );

    always #HALF clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the two maps, commit-pending flag, frame counter, and
    // the previous-edge values of wr_ack and the frame condition.
    int shadow_m [20];
    int active_m [20];
    bit pending_m;
    int blink_m;
    bit ack_prev_m;
    bit frame_prev_m;
    logic [11:0] palette [8] = '{12'h444, 12'h00F, 12'h0F0, 12'hF00,
                                 12'hFF0, 12'hF0F, 12'h08F, 12'hFFF};

    task automatic model_reset();
        for (int i = 0; i < 20; i++) begin
            shadow_m[i] = 0;
            active_m[i] = 0;
        end
        pending_m    = 1'b0;
        blink_m      = 0;
        ack_prev_m   = 1'b0;
        frame_prev_m = 1'b0;
    endtask

    function automatic logic [11:0] exp_pix(input int r, input int c, input bit rd);
        int tx, ty, lx, ly;
        if (rd) return 12'h000;
        if (c < 128 || c > 511 || r > 479) return 12'h000;
        tx = (c - 128) / 96;
        lx = (c - 128) % 96;
        ty = r / 96;
        ly = r % 96;
        if (lx < 2 || lx > 93 || ly < 2 || ly > 93)
            return (cursor_en && tx == int'(cursor_x) && ty == int'(cursor_y) && blink_m < 16)
                   ? 12'h0FF : 12'h000;
        return palette[active_m[ty * 4 + tx]];
    endfunction

    // One clock cycle of bus/frame stimulus; checks the registered pulses.
    task automatic cycle(input bit do_wr, input int x, input int y, input int code,
                         input bit do_commit, input bit do_frame);
        bit acc, fs, swap;
        bus.wr_req  = do_wr;
        bus.wr_x    = 2'(x);
        bus.wr_y    = 3'(y);
        bus.wr_code = 3'(code);
        bus.commit  = do_commit;
        rdn         = do_frame;
        row         = do_frame ? 9'd480 : 9'd0;
        col         = 10'd0;
        @(posedge clk);
        acc  = do_wr && !ack_prev_m;
        fs   = do_frame && !frame_prev_m;
        swap = fs && pending_m;
        if (swap) begin
            active_m  = shadow_m;
            pending_m = do_commit;
        end else begin
            pending_m = pending_m | do_commit;
        end
        if (acc && y <= 4) shadow_m[y * 4 + x] = code;
        if (fs) blink_m = (blink_m + 1) % 32;
        ack_prev_m   = acc;
        frame_prev_m = do_frame;
        @(negedge clk);
        bus.wr_req = 1'b0;
        bus.commit = 1'b0;
        rdn        = 1'b0;
        row        = 9'd0;
        #1;
        checks++;
        if (bus.wr_ack !== acc) begin
            errors++;
            $display("FAIL wr_ack t=%0t: got %b expected %b", $time, bus.wr_ack, acc);
        end
        checks++;
        if (bus.commit_done !== swap) begin
            errors++;
            $display("FAIL commit_done t=%0t: got %b expected %b", $time, bus.commit_done, swap);
        end
    endtask

    task automatic idle();
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic check_pix(input int r, input int c, input bit rd, input string name);
        logic [11:0] exp;
        row = 9'(r);
        col = 10'(c);
        rdn = rd;
        #1;
        exp = exp_pix(r, c, rd);
        checks++;
        if (dout !== exp) begin
            errors++;
            $display("FAIL %s row=%0d col=%0d rdn=%0b: dout=%h expected %h",
                     name, r, c, rd, dout, exp);
        end
        row = 9'd0;
        col = 10'd0;
        rdn = 1'b0;
    endtask

    task automatic check_all_tiles(input string name);
        for (int t = 0; t < 20; t++)
            check_pix((t / 4) * 96 + 48, 128 + (t % 4) * 96 + 48, 1'b0, name);
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge clk);
        #1;
        checks++;
        if (bus.wr_ack !== 1'b0 || bus.commit_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: wr_ack=%b commit_done=%b expected 0 0",
                     bus.wr_ack, bus.commit_done);
        end
        check_pix(50, 200, 1'b0, "in_reset_fill");
        check_pix(0, 128, 1'b0, "in_reset_border");
        check_pix(50, 100, 1'b0, "in_reset_left");
        rstn = 1'b1;
        check_pix(50, 200, 1'b0, "after_reset_fill");
        check_pix(50, 100, 1'b0, "after_reset_left");
        check_pix(50, 200, 1'b1, "after_reset_rdn");
        check_pix(50, 600, 1'b0, "after_reset_right");
    endtask

    task automatic test_write_no_commit();
        cycle(1'b1, 1, 2, 1, 1'b0, 1'b0);
        idle();
        check_pix(200, 274, 1'b0, "write_no_commit");
    endtask

    task automatic test_commit_swap();
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
        idle();
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
        idle();
        check_pix(200, 274, 1'b0, "commit_swap");
        check_all_tiles("commit_swap_all");
    endtask

    task automatic test_double_commit();
        cycle(1'b1, 3, 0, 4, 1'b1, 1'b0);
        idle();
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
        idle();
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
        idle();
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
        idle();
        check_all_tiles("double_commit");
        // Commit and a write both on the swap edge.
        cycle(1'b1, 0, 4, 3, 1'b1, 1'b0);
        idle();
        cycle(1'b1, 3, 4, 6, 1'b1, 1'b1);
        idle();
        check_all_tiles("write_on_swap");
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
        idle();
        check_all_tiles("commit_next_frame");
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 2, 1, 5, 1'b0, 1'b0);
        cycle(1'b1, 2, 1, 7, 1'b0, 1'b0);
        cycle(1'b1, 1, 1, 2, 1'b0, 1'b0);
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b1);
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
        idle();
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
        idle();
        check_all_tiles("back_to_back");
    endtask

    task automatic test_bad_row();
        cycle(1'b1, 1, 5, 7, 1'b0, 1'b0);
        cycle(1'b1, 3, 7, 6, 1'b1, 1'b0);
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
        idle();
        check_all_tiles("bad_row");
    endtask

    task automatic test_cursor_blink();
        cursor_en = 1'b1;
        cursor_x  = 2'd0;
        cursor_y  = 3'd0;
        for (int f = 0; f < 34; f++) begin
            check_pix(0, 128, 1'b0, "cursor_corner");
            check_pix(95, 223, 1'b0, "cursor_far_corner");
            check_pix(0, 224, 1'b0, "cursor_other_tile");
            cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
            idle();
        end
        cursor_en = 1'b0;
        check_pix(0, 128, 1'b0, "cursor_off");
    endtask

    task automatic test_reset_pending();
        cycle(1'b1, 2, 2, 3, 1'b1, 1'b0);
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_ack: got %b expected 0", bus.wr_ack);
        end
        model_reset();
        check_pix(200, 274, 1'b0, "async_reset_map");
        @(negedge clk);
        rstn = 1'b1;
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
        idle();
        check_all_tiles("reset_lost_commit");
    endtask

    task automatic test_random();
        bit wr, cm, fr;
        for (int n = 0; n < 400; n++) begin
            wr = ($urandom % 2) == 0;
            cm = ($urandom % 5) == 0;
            fr = ($urandom % 6) == 0;
            if (($urandom % 16) == 0) begin
                cursor_en = 1'($urandom);
                cursor_x  = 2'($urandom);
                cursor_y  = 3'($urandom_range(0, 4));
            end
            cycle(wr, int'($urandom % 4), int'($urandom % 8), int'($urandom % 8), cm, fr);
            for (int k = 0; k < 3; k++)
                check_pix(int'($urandom % 512), int'($urandom_range(100, 540)),
                          1'(($urandom % 8) == 0), "random_pix");
            if ((n % 50) == 49) check_all_tiles("random_sweep");
        end
    endtask

    initial begin
        bus.wr_req  = 1'b0;
        bus.wr_x    = 2'd0;
        bus.wr_y    = 3'd0;
        bus.wr_code = 3'd0;
        bus.commit  = 1'b0;
        test_reset();
        test_write_no_commit();
        test_commit_swap();
        test_double_commit();
        test_back_to_back();
        test_bad_row();
        test_cursor_blink();
        test_reset_pending();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vga_tile_renderer.md
VGA_TILE_RENDERER -- requirements
Module: vga_tile_renderer

Interface
REQ-001 clk  in  1  pixel clock, 25 MHz; all state changes on rising edge.
REQ-002 rstn  in  1  reset, asynchronous, active-low.
REQ-003 rdn  in  1  pixel read strobe from the VGA timing generator, active-low.
REQ-004 row  in  9  pixel row address, visible range 0-479.
REQ-005 col  in  10  pixel column address, visible range 0-639.
REQ-006 dout  out  12  pixel colour, bbbb_gggg_rrrr, returned to the VGA timing generator's Din.
REQ-007 wr_req  in  1  write request from game logic, level, held until wr_ack.
REQ-008 wr_x  in  2  write target tile column, 0-3.
REQ-009 wr_y  in  3  write target tile row, 0-4.
REQ-010 wr_code  in  3  tile code; 0 = empty, 1-7 = piece colour id.
REQ-011 wr_ack  out  1  one-cycle write-accept pulse.
REQ-012 commit  in  1  one-cycle pulse requesting shadow-to-active map swap.
REQ-013 commit_done  out  1  one-cycle pulse when the swap executes.
REQ-014 cursor_en, cursor_x[1:0], cursor_y[2:0]  in  cursor enable and tile position.

Function
REQ-015 Board: 4x5 tiles of 96x96 px; board spans col 128-511, row 0-479; tx = (col-128)/96, ty = row/96, local lx/ly = remainder.
REQ-016 Two 20-entry x 3-bit maps: shadow (written by game logic) and active (displayed); dout depends only on active.
REQ-017 dout is combinational from row, col, rdn and registered state; zero added latency.
REQ-018 rdn=1 -> dout=12'h000; col<128 or col>511 -> 12'h000.
REQ-019 In-board colour priority: border (lx or ly in {0,1,94,95}), then fill.
REQ-020 Border colour: 12'h0FF (yellow) if cursor_en, tile==(cursor_x,cursor_y) and blink[4]==0; otherwise 12'h000.
REQ-021 Fill by code: 0 12'h444, 1 12'h00F, 2 12'h0F0, 3 12'hF00, 4 12'hFF0, 5 12'hF0F, 6 12'h08F, 7 12'hFFF.
REQ-022 Write handshake: sample wr_req=1 while wr_ack=0 -> write shadow[wr_y][wr_x] on that edge and assert wr_ack for the next cycle; max one write per two cycles.
REQ-023 wr_y>4: no map change, wr_ack still pulses.
REQ-024 commit sets pending; a commit while pending already set merges into one swap and one commit_done.
REQ-025 frame_start = (rdn=1 and row==480) this cycle and not the previous cycle; a one-cycle edge detect.
REQ-026 On frame_start with pending=1: copy all 20 shadow entries to active in one cycle, clear pending, pulse commit_done the next cycle.
REQ-027 Write accepted on the swap edge: lands in shadow only and is not copied in that swap.
REQ-028 commit on the swap edge: pending stays set for the next frame.
REQ-029 commit and write accepted on the same edge with no swap: write is included in the pending swap.
REQ-030 blink: 5-bit frame counter, +1 on every frame_start, wraps 31->0.

Reset
REQ-031 rstn=0 immediately clears both maps to 0, pending, blink and the frame_start history; wr_ack=0, commit_done=0.
REQ-032 While rstn=0, dout still follows REQ-018/021 with empty maps: board tiles 12'h444, borders 12'h000.
REQ-033 Reset mid-handshake or with a commit pending: the write or commit is lost; the requester must re-issue after reset.

Verification
REQ-034 After reset, rdn=0, row=50, col=200 -> dout=12'h444; col=100 -> 12'h000; rdn=1 -> 12'h000.
REQ-035 Write (x=1,y=2,code=1), no commit -> wr_ack pulses one cycle; pixel row=200,col=274 stays 12'h444.
REQ-036 Same write, then commit, then row=480,rdn=1 -> commit_done pulses once; pixel row=200,col=274 = 12'h00F.
REQ-037 Two commits before a frame boundary -> exactly one commit_done; a commit on the swap edge -> second commit_done one frame later.
REQ-038 cursor_en=1 at (0,0), pixel row=0,col=128 -> 12'h0FF for frames with blink 0-15, 12'h000 for blink 16-31.
REQ-039 wr_y=5 -> wr_ack pulses; after commit, all 20 tiles unchanged.
